// File: rtl/reloj_pkg.sv
// Shared constants and types for the clock display path: active-low segment
// patterns, digit count and the digit-index type.
package reloj_pkg;

  localparam int N_DIG = 4;

  typedef logic [1:0] dig_idx_t;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [N_DIG-1:0] AN_OFF = '1;

  function automatic logic [N_DIG-1:0] an_select_n(input dig_idx_t idx);
    return ~(N_DIG'(1) << idx);
  endfunction

endpackage

// File: rtl/bcd_a_7seg.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 show a
// dash so a corrupted counter value is visible on the board.
module bcd_a_7seg
  import reloj_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/reloj_display.sv
// Multiplexed 4-digit common-anode display driver with shadowed digits and an
// all-off guard interval at the start of each digit slot.
module reloj_display
  import reloj_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic [3:0] md,
  input  logic [3:0] mu,
  input  logic [3:0] sd,
  input  logic [3:0] su,
  input  logic       colon,
  input  logic       blank_lead,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  dig_idx_t         idx_q, idx_d;
  logic [3:0]       sh_md_q, sh_md_d;
  logic [3:0]       sh_mu_q, sh_mu_d;
  logic [3:0]       sh_sd_q, sh_sd_d;
  logic [3:0]       sh_su_q, sh_su_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             slot_end;
  logic             dark;
  logic [3:0]       cur_digit;
  logic [6:0]       cur_seg;

  bcd_a_7seg u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  // Scan timing and shadow capture; upd and slot-end may land on the same edge.
  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    cnt_d    = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d    = slot_end ? idx_q + dig_idx_t'(1) : idx_q;
    sh_md_d  = upd ? md : sh_md_q;
    sh_mu_d  = upd ? mu : sh_mu_q;
    sh_sd_d  = upd ? sd : sh_sd_q;
    sh_su_d  = upd ? su : sh_su_q;
  end

  always_comb begin
    cur_digit = sh_su_q;
    case (idx_q)
      2'd0:    cur_digit = sh_su_q;
      2'd1:    cur_digit = sh_sd_q;
      2'd2:    cur_digit = sh_mu_q;
      default: cur_digit = sh_md_q;
    endcase
  end

  // A blanked leading digit reuses the guard path so the whole slot stays dark.
  always_comb begin
    dark  = (cnt_q < CNT_GUARD) ||
            (blank_lead && (sh_md_q == 4'd0) && (idx_q == dig_idx_t'(3)));
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!dark) begin
      an_d  = an_select_n(idx_q);
      seg_d = cur_seg;
      dp_d  = !((idx_q == dig_idx_t'(2)) && colon);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_md_q <= '0;
      sh_mu_q <= '0;
      sh_sd_q <= '0;
      sh_su_q <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_md_q <= sh_md_d;
      sh_mu_q <= sh_mu_d;
      sh_sd_q <= sh_sd_d;
      sh_su_q <= sh_su_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_reloj_display.sv
// Directed bench for reloj_display with SCAN_DIV=8, GUARD=2; every cycle is
// checked against a small scan model using a hand-written segment table.
module tb_reloj_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       upd;
  logic [3:0] md, mu, sd, su;
  logic       colon;
  logic       blank_lead;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Model state: scan position and shadow contents after the latest edge.
  int         m_cnt = 0;
  int         m_idx = 0;
  logic [3:0] m_md = '0, m_mu = '0, m_sd = '0, m_su = '0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  reloj_display #(.SCAN_DIV(8), .GUARD(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .upd        (upd),
    .md         (md),
    .mu         (mu),
    .sd         (sd),
    .su         (su),
    .colon      (colon),
    .blank_lead (blank_lead),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] v_md, input logic [3:0] v_mu,
                                input logic [3:0] v_sd, input logic [3:0] v_su);
    md = v_md;
    mu = v_mu;
    sd = v_sd;
    su = v_su;
  endtask

  // One clock edge: predict outputs from the pre-edge model, step the model,
  // then compare after the edge.
  task automatic tick();
    logic [3:0] dig;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    e_an  = 4'b1111;
    e_seg = 7'b1111111;
    e_dp  = 1'b1;
    case (m_idx)
      0:       dig = m_su;
      1:       dig = m_sd;
      2:       dig = m_mu;
      default: dig = m_md;
    endcase
    if (!rst && m_cnt >= 2 && !(blank_lead && m_md == 4'd0 && m_idx == 3)) begin
      e_an  = ~(4'b0001 << m_idx);
      e_seg = seg_tab[dig];
      e_dp  = !(m_idx == 2 && colon);
    end
    if (rst) begin
      m_cnt = 0;
      m_idx = 0;
      m_md = '0; m_mu = '0; m_sd = '0; m_su = '0;
    end else begin
      if (upd) begin
        m_md = md; m_mu = mu; m_sd = sd; m_su = su;
      end
      if (m_cnt == 7) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_output($sformatf("an@%0d", cyc), {3'b000, an}, {3'b000, e_an});
    check_output($sformatf("seg@%0d", cyc), seg, e_seg);
    check_output($sformatf("dp@%0d", cyc), {6'b000000, dp}, {6'b000000, e_dp});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int lit_cycles;
    rst        = 1'b1;
    upd        = 1'b0;
    colon      = 1'b0;
    blank_lead = 1'b0;
    apply_stimulus(4'd0, 4'd0, 4'd0, 4'd0);
    run(2);
    rst = 1'b0;
    check_output("reset_an", {3'b000, an}, 7'b0001111);
    check_output("reset_seg", seg, 7'b1111111);
    check_output("reset_dp", {6'b000000, dp}, 7'b0000001);

    $display("[TB] basic scan with 1,2,3,4");
    apply_stimulus(4'd1, 4'd2, 4'd3, 4'd4);
    upd = 1'b1;
    tick();
    upd = 1'b0;
    lit_cycles = 0;
    for (int i = 0; i < 31; i++) begin
      tick();
      if (an == 4'b1110) lit_cycles++;
    end
    checks++;
    assert (lit_cycles == 6)
    else begin
      fails++;
      $error("FAIL lit_cycles_idx0: observed %0d expected 6", lit_cycles);
    end

    $display("[TB] full decode on idx0");
    for (int v = 0; v < 16; v++) begin
      apply_stimulus(4'd1, 4'd2, 4'd3, 4'(v));
      upd = 1'b1;
      tick();
      upd = 1'b0;
      run(2);
      check_output($sformatf("decode_%0d", v), seg, seg_tab[v]);
      run(29);
    end

    $display("[TB] leading blank");
    apply_stimulus(4'd0, 4'd2, 4'd3, 4'd4);
    blank_lead = 1'b1;
    upd = 1'b1;
    tick();
    upd = 1'b0;
    run(31);
    apply_stimulus(4'd5, 4'd2, 4'd3, 4'd4);
    upd = 1'b1;
    tick();
    upd = 1'b0;
    run(27);
    check_output("blank_md5_seg", seg, 7'b0010010);
    run(4);
    blank_lead = 1'b0;

    $display("[TB] colon");
    colon = 1'b1;
    run(32);
    colon = 1'b0;

    $display("[TB] tear-free update");
    apply_stimulus(4'd9, 4'd8, 4'd7, 4'd6);
    run(32);
    run(7);
    upd = 1'b1;
    tick();
    upd = 1'b0;
    run(3);
    check_output("tearfree_sd", seg, 7'b1111000);
    run(20);

    $display("[TB] reset mid-scan");
    for (int i = 0; i < 64 && !(m_idx == 2 && m_cnt == 5); i++) tick();
    check_output("reach_idx2_cnt5", {5'b00000, m_idx[1:0]}, 7'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("midrst_an", {3'b000, an}, 7'b0001111);
    check_output("midrst_seg", seg, 7'b1111111);
    run(3);
    check_output("midrst_idx0_an", {3'b000, an}, 7'b0001110);
    check_output("midrst_idx0_seg", seg, 7'b1000000);
    run(8);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
